// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and its loopback checker.
//   DEF_PRESCALE_W / DEF_BITCNT_W : default widths of the prescale and bit count
//   PRESCALE_8/16/32              : the only legal oversampling ratios
//   win_state_e                   : progress through the three-sample window
//   majority3()                   : 2-of-3 vote, also used by the TX checker
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_PRESCALE_W = 6;
    localparam int DEF_BITCNT_W   = 4;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // WIN_GOTn means sample n has been captured and the next one is due.
    typedef enum logic [1:0] {
        WIN_IDLE = 2'd0,
        WIN_GOT0 = 2'd1,
        WIN_GOT1 = 2'd2,
        WIN_GOT2 = 2'd3
    } win_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler_if
// Bundle between the RX control FSM and the oversampling stage.
//   counter_enable, data_sample_en : FSM -> sampler controls
//   rx_sync                        : synchronised serial line
//   edge_count, bit_count          : oversample index and completed bit periods
//   sampled_bit, sample_valid,
//   sample_noisy                   : voted bit, its strobe and disagreement flag
// Modports: master = RX control FSM, slave = uart_rx_sampler.
// -----------------------------------------------------------------------------
interface uart_rx_sampler_if #(
    parameter int PRESCALE_W = uart_pkg::DEF_PRESCALE_W,
    parameter int BITCNT_W   = uart_pkg::DEF_BITCNT_W
) ();

    logic                  counter_enable;
    logic                  data_sample_en;
    logic                  rx_sync;
    logic [PRESCALE_W-1:0] edge_count;
    logic [BITCNT_W-1:0]   bit_count;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  sample_noisy;

    modport master (
        output counter_enable,
        output data_sample_en,
        input  rx_sync,
        input  edge_count,
        input  bit_count,
        input  sampled_bit,
        input  sample_valid,
        input  sample_noisy
    );

    modport slave (
        input  counter_enable,
        input  data_sample_en,
        output rx_sync,
        output edge_count,
        output bit_count,
        output sampled_bit,
        output sample_valid,
        output sample_noisy
    );

endinterface

// File: rtl/uart_bit_sync.sv
// -----------------------------------------------------------------------------
// uart_bit_sync
// Multi-flop synchroniser for a single asynchronous bit. Flops reset to 1 so
// an idle-high serial line does not look like a start bit after reset.
//   clk  : destination clock
//   rst  : asynchronous, active-low reset
//   d_i  : asynchronous input
//   q_o  : d_i delayed by exactly SYNC_STAGES clk cycles
// -----------------------------------------------------------------------------
module uart_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Oversampling timing and data-recovery stage of the UART receiver.
//   clk       : oversampling clock
//   rst       : asynchronous, active-low reset
//   RX_IN     : raw serial line (asynchronous, idle high)
//   Prescale  : oversampling ratio, 8/16/32 (anything else is treated as 8)
//   fsm       : slave side of uart_rx_sampler_if (controls in, counters and
//               voted sample out)
// The ratio is latched while counter_enable is low and on the first enabled
// cycle, so it stays fixed for a whole frame. Three samples are taken around
// mid-bit (mid-1, mid, mid+1) and voted at mid+2; the registered result is
// visible the cycle after.
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE_W  = uart_pkg::DEF_PRESCALE_W,
    parameter int BITCNT_W    = uart_pkg::DEF_BITCNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    uart_rx_sampler_if.slave      fsm
);

    import uart_pkg::*;

    // Any ratio other than 16 or 32 falls back to 8.
    function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
        case (p)
            PRESCALE_W'(PRESCALE_16),
            PRESCALE_W'(PRESCALE_32): return p;
            default:                  return PRESCALE_W'(PRESCALE_8);
        endcase
    endfunction

    // Bit count sticks at all-ones instead of wrapping.
    function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] v);
        return (&v) ? v : v + BITCNT_W'(1);
    endfunction

    logic                  rx_sync;
    logic                  ce;
    logic                  ds;

    logic                  ce_q;
    logic [PRESCALE_W-1:0] p_q,    p_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BITCNT_W-1:0]   bit_q,  bit_d;
    win_state_e            win_q,  win_d;
    logic                  sbit_q, sbit_d;
    logic                  valid_q, valid_d;
    logic                  noisy_q, noisy_d;
    logic                  s0_q, s1_q, s2_q;
    logic                  cap0, cap1, cap2;

    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] mid_m1;
    logic [PRESCALE_W-1:0] mid_p1;
    logic [PRESCALE_W-1:0] mid_p2;

    uart_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (RX_IN),
        .q_o (rx_sync)
    );

    assign ce = fsm.counter_enable;
    assign ds = fsm.data_sample_en;

    assign last_edge = p_q - PRESCALE_W'(1);
    assign mid       = p_q >> 1;
    assign mid_m1    = mid - PRESCALE_W'(1);
    assign mid_p1    = mid + PRESCALE_W'(1);
    assign mid_p2    = mid + PRESCALE_W'(2);

    // ce_q low marks the first enabled cycle, which still re-latches Prescale.
    always_comb begin
        p_d = p_q;
        if (!ce || !ce_q) begin
            p_d = legal_prescale(Prescale);
        end
    end

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!ce) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (edge_q >= last_edge) begin
            edge_d = '0;
            bit_d  = sat_inc(bit_q);
        end else begin
            edge_d = edge_q + PRESCALE_W'(1);
        end
    end

    // Window sequencer: each step only advances if the previous sample was
    // taken on the immediately preceding edge with both enables high, so a
    // late-starting or interrupted window falls back to idle without a result.
    always_comb begin
        win_d   = WIN_IDLE;
        sbit_d  = sbit_q;
        noisy_d = 1'b0;
        valid_d = 1'b0;
        cap0    = 1'b0;
        cap1    = 1'b0;
        cap2    = 1'b0;
        if (ce && ds) begin
            case (win_q)
                WIN_IDLE: begin
                    if (edge_q == mid_m1) begin
                        win_d = WIN_GOT0;
                        cap0  = 1'b1;
                    end
                end
                WIN_GOT0: begin
                    if (edge_q == mid) begin
                        win_d = WIN_GOT1;
                        cap1  = 1'b1;
                    end
                end
                WIN_GOT1: begin
                    if (edge_q == mid_p1) begin
                        win_d = WIN_GOT2;
                        cap2  = 1'b1;
                    end
                end
                WIN_GOT2: begin
                    if (edge_q == mid_p2) begin
                        sbit_d  = majority3(s0_q, s1_q, s2_q);
                        noisy_d = !((s0_q == s1_q) && (s1_q == s2_q));
                        valid_d = 1'b1;
                    end
                end
                default: win_d = WIN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q    <= 1'b0;
            p_q     <= PRESCALE_W'(PRESCALE_8);
            edge_q  <= '0;
            bit_q   <= '0;
            win_q   <= WIN_IDLE;
            sbit_q  <= 1'b1;
            valid_q <= 1'b0;
            noisy_q <= 1'b0;
        end else begin
            ce_q    <= ce;
            p_q     <= p_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            win_q   <= win_d;
            sbit_q  <= sbit_d;
            valid_q <= valid_d;
            noisy_q <= noisy_d;
        end
    end

    // Raw samples are only ever read after the sequencer has written them.
    always_ff @(posedge clk) begin
        if (cap0) s0_q <= rx_sync;
        if (cap1) s1_q <= rx_sync;
        if (cap2) s2_q <= rx_sync;
    end

    assign fsm.rx_sync      = rx_sync;
    assign fsm.edge_count   = edge_q;
    assign fsm.bit_count    = bit_q;
    assign fsm.sampled_bit  = sbit_q;
    assign fsm.sample_valid = valid_q;
    assign fsm.sample_noisy = noisy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Directed bench for uart_rx_sampler. Inputs change and outputs are read on the
// falling clock edge. After the k-th rising edge of an enabled frame the
// expected edge_count is k mod P and bit_count is k / P; a vote made at edge
// mid+2 is seen while edge_count reads mid+3. RX_IN is driven two cycles ahead
// of the edge it is meant to be sampled at (SYNC_STAGES = 2).
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx_sampler_if #(.PRESCALE_W(6), .BITCNT_W(4)) bus ();

    uart_rx_sampler #(
        .SYNC_STAGES (2),
        .PRESCALE_W  (6),
        .BITCNT_W    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX_IN    (RX_IN),
        .Prescale (Prescale),
        .fsm      (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus.rx_sync !== 1'b1) begin miscompares++; $display("FAIL rst_rx_sync got=%b exp=1", bus.rx_sync); end
        vectors++; if (bus.edge_count !== 6'd0) begin miscompares++; $display("FAIL rst_edge got=%0d exp=0", bus.edge_count); end
        vectors++; if (bus.bit_count !== 4'd0) begin miscompares++; $display("FAIL rst_bit got=%0d exp=0", bus.bit_count); end
        vectors++; if (bus.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL rst_sampled got=%b exp=1", bus.sampled_bit); end
        vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", bus.sample_valid); end
        vectors++; if (bus.sample_noisy !== 1'b0) begin miscompares++; $display("FAIL rst_noisy got=%b exp=0", bus.sample_noisy); end
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid k=%0d got=%b exp=0", k, bus.sample_valid); end
            vectors++; if (bus.edge_count !== 6'd0) begin miscompares++; $display("FAIL idle_edge k=%0d got=%0d exp=0", k, bus.edge_count); end
            vectors++; if (bus.rx_sync !== 1'b1) begin miscompares++; $display("FAIL idle_rx_sync k=%0d got=%b exp=1", k, bus.rx_sync); end
        end
    endtask

    task automatic test_p8_counting();
        logic [5:0] exp_e;
        logic [3:0] exp_b;
        logic       exp_v;
        Prescale = 6'd8;
        RX_IN = 1'b0;
        @(negedge clk);
        vectors++; if (bus.rx_sync !== 1'b1) begin miscompares++; $display("FAIL sync_delay1 got=%b exp=1", bus.rx_sync); end
        @(negedge clk);
        vectors++; if (bus.rx_sync !== 1'b0) begin miscompares++; $display("FAIL sync_delay2 got=%b exp=0", bus.rx_sync); end
        bus.counter_enable = 1'b1; bus.data_sample_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 8);
            exp_b = 4'(k / 8);
            exp_v = ((k % 8) == 7);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL p8_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
            vectors++; if (bus.bit_count !== exp_b) begin miscompares++; $display("FAIL p8_bit k=%0d got=%0d exp=%0d", k, bus.bit_count, exp_b); end
            vectors++; if (bus.sample_valid !== exp_v) begin miscompares++; $display("FAIL p8_valid k=%0d got=%b exp=%b", k, bus.sample_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL p8_sampled k=%0d got=%b exp=0", k, bus.sampled_bit); end
                vectors++; if (bus.sample_noisy !== 1'b0) begin miscompares++; $display("FAIL p8_noisy k=%0d got=%b exp=0", k, bus.sample_noisy); end
            end
        end
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        @(negedge clk);
        vectors++; if (bus.edge_count !== 6'd0) begin miscompares++; $display("FAIL p8_clr_edge got=%0d exp=0", bus.edge_count); end
        vectors++; if (bus.bit_count !== 4'd0) begin miscompares++; $display("FAIL p8_clr_bit got=%0d exp=0", bus.bit_count); end
    endtask

    task automatic test_bit_saturate();
        logic [3:0] exp_b;
        Prescale = 6'd8;
        bus.counter_enable = 1'b1; bus.data_sample_en = 1'b0;
        for (int k = 1; k <= 144; k++) begin
            @(negedge clk);
            if ((k % 8) == 0) begin
                exp_b = (k / 8 > 15) ? 4'd15 : 4'(k / 8);
                vectors++; if (bus.bit_count !== exp_b) begin miscompares++; $display("FAIL sat_bit k=%0d got=%0d exp=%0d", k, bus.bit_count, exp_b); end
            end
            vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL sat_valid k=%0d got=%b exp=0", k, bus.sample_valid); end
        end
        bus.counter_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_p16_noisy();
        logic [5:0] exp_e;
        logic       exp_v;
        logic       exp_s;
        int         tgt;
        int         b;
        Prescale = 6'd16; RX_IN = 1'b1;
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        repeat (3) @(negedge clk);
        bus.counter_enable = 1'b1; bus.data_sample_en = 1'b1;
        RX_IN = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 16);
            exp_v = (k == 11) || (k == 27);
            exp_s = (k >= 16);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL p16_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
            vectors++; if (bus.sample_valid !== exp_v) begin miscompares++; $display("FAIL p16_valid k=%0d got=%b exp=%b", k, bus.sample_valid, exp_v); end
            vectors++; if (bus.sample_noisy !== exp_v) begin miscompares++; $display("FAIL p16_noisy k=%0d got=%b exp=%b", k, bus.sample_noisy, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.sampled_bit !== exp_s) begin miscompares++; $display("FAIL p16_sampled k=%0d got=%b exp=%b", k, bus.sampled_bit, exp_s); end
            end
            tgt = (k + 2) % 16;
            b   = (k + 2) / 16;
            RX_IN = 1'b1;
            if (tgt >= 7 && tgt <= 9) RX_IN = (b == 0) ? (tgt == 8) : (tgt != 8);
        end
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_prescale_change();
        logic [5:0] exp_e;
        logic [3:0] exp_b;
        logic       exp_v;
        Prescale = 6'd16; RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        bus.counter_enable = 1'b1; bus.data_sample_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 16);
            exp_b = 4'(k / 16);
            exp_v = ((k % 16) == 11);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL chg16_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
            vectors++; if (bus.bit_count !== exp_b) begin miscompares++; $display("FAIL chg16_bit k=%0d got=%0d exp=%0d", k, bus.bit_count, exp_b); end
            vectors++; if (bus.sample_valid !== exp_v) begin miscompares++; $display("FAIL chg16_valid k=%0d got=%b exp=%b", k, bus.sample_valid, exp_v); end
            if (k == 5) Prescale = 6'd32;
        end
        bus.counter_enable = 1'b0;
        @(negedge clk);
        vectors++; if (bus.edge_count !== 6'd0) begin miscompares++; $display("FAIL chg_restart_edge got=%0d exp=0", bus.edge_count); end
        vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL chg_restart_valid got=%b exp=0", bus.sample_valid); end
        bus.counter_enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 32);
            exp_b = 4'(k / 32);
            exp_v = ((k % 32) == 19);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL chg32_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
            vectors++; if (bus.bit_count !== exp_b) begin miscompares++; $display("FAIL chg32_bit k=%0d got=%0d exp=%0d", k, bus.bit_count, exp_b); end
            vectors++; if (bus.sample_valid !== exp_v) begin miscompares++; $display("FAIL chg32_valid k=%0d got=%b exp=%b", k, bus.sample_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL chg32_sampled k=%0d got=%b exp=1", k, bus.sampled_bit); end
            end
        end
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal_prescale();
        logic [5:0] exp_e;
        logic       exp_v;
        int         tgt;
        Prescale = 6'd5; RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        bus.counter_enable = 1'b1; bus.data_sample_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 8);
            exp_v = ((k % 8) == 7);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL ill_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
            vectors++; if (bus.sample_valid !== exp_v) begin miscompares++; $display("FAIL ill_valid k=%0d got=%b exp=%b", k, bus.sample_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL ill_sampled k=%0d got=%b exp=0", k, bus.sampled_bit); end
                vectors++; if (bus.sample_noisy !== 1'b1) begin miscompares++; $display("FAIL ill_noisy k=%0d got=%b exp=1", k, bus.sample_noisy); end
            end
            tgt = (k + 2) % 8;
            RX_IN = !(tgt == 4 || tgt == 5);
        end
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sample_enable();
        logic [5:0] exp_e;
        logic       exp_v;
        Prescale = 6'd8; RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        bus.counter_enable = 1'b1; bus.data_sample_en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 8);
            exp_v = (k == 23);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL den_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
            vectors++; if (bus.sample_valid !== exp_v) begin miscompares++; $display("FAIL den_valid k=%0d got=%b exp=%b", k, bus.sample_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL den_sampled k=%0d got=%b exp=0", k, bus.sampled_bit); end
                vectors++; if (bus.sample_noisy !== 1'b0) begin miscompares++; $display("FAIL den_noisy k=%0d got=%b exp=0", k, bus.sample_noisy); end
            end
            bus.data_sample_en = !((k == 5) || (k >= 8 && k <= 11));
        end
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [5:0] exp_e;
        logic       exp_v;
        Prescale = 6'd16; RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        bus.counter_enable = 1'b1; bus.data_sample_en = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 16);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL mid_pre_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
        end
        vectors++; if (bus.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL mid_pre_sampled got=%b exp=0", bus.sampled_bit); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.edge_count !== 6'd0) begin miscompares++; $display("FAIL mid_rst_edge got=%0d exp=0", bus.edge_count); end
        vectors++; if (bus.bit_count !== 4'd0) begin miscompares++; $display("FAIL mid_rst_bit got=%0d exp=0", bus.bit_count); end
        vectors++; if (bus.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL mid_rst_sampled got=%b exp=1", bus.sampled_bit); end
        vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got=%b exp=0", bus.sample_valid); end
        vectors++; if (bus.sample_noisy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_noisy got=%b exp=0", bus.sample_noisy); end
        vectors++; if (bus.rx_sync !== 1'b1) begin miscompares++; $display("FAIL mid_rst_rx_sync got=%b exp=1", bus.rx_sync); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL mid_hold_valid k=%0d got=%b exp=0", k, bus.sample_valid); end
            vectors++; if (bus.edge_count !== 6'd0) begin miscompares++; $display("FAIL mid_hold_edge k=%0d got=%0d exp=0", k, bus.edge_count); end
        end
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_e = 6'(k % 16);
            exp_v = (k == 11);
            vectors++; if (bus.edge_count !== exp_e) begin miscompares++; $display("FAIL mid_post_edge k=%0d got=%0d exp=%0d", k, bus.edge_count, exp_e); end
            vectors++; if (bus.sample_valid !== exp_v) begin miscompares++; $display("FAIL mid_post_valid k=%0d got=%b exp=%b", k, bus.sample_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL mid_post_sampled k=%0d got=%b exp=0", k, bus.sampled_bit); end
            end
        end
        vectors++; if (bus.bit_count !== 4'd1) begin miscompares++; $display("FAIL mid_post_bit got=%0d exp=1", bus.bit_count); end
        bus.counter_enable = 1'b0; bus.data_sample_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        RX_IN = 1'b1;
        Prescale = 6'd8;
        bus.counter_enable = 1'b0;
        bus.data_sample_en = 1'b0;
        test_reset();
        test_p8_counting();
        test_bit_saturate();
        test_p16_noisy();
        test_prescale_change();
        test_illegal_prescale();
        test_sample_enable();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
